// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between the processor (port 0) and a loader/DMA (port 1).
// The winning request is latched, the memory is strobed for MEM_LAT cycles, then the owner gets a one-cycle ack.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int PRIO_RR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_owner;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_any_req;
    logic              w_winner;

    // Ties alternate away from the last granted port in round-robin mode.
    always_comb begin
        w_any_req = p0_req | p1_req;
        w_winner  = 1'b0;
        if (p0_req && p1_req) begin
            w_winner = (PRIO_RR != 0) ? ~r_last_grant : 1'b0;
        end else if (p1_req) begin
            w_winner = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_any_req) w_state_next = StAccess;
            StAccess: if (r_cnt == '0) w_state_next = StResp;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_we    <= w_winner ? p1_we : p0_we;
                        r_addr  <= w_winner ? p1_addr : p0_addr;
                        r_wdata <= w_winner ? p1_wdata : p0_wdata;
                        r_cnt   <= CNT_W'(MEM_LAT - 1);
                    end
                end
                StAccess: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0 && !r_we) begin
                        if (r_owner) begin
                            r_rdata1 <= mem_rdata;
                        end else begin
                            r_rdata0 <= mem_rdata;
                        end
                    end
                end
                StResp: begin
                    r_last_grant <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes and acks decode the state directly so an async reset drops them at once.
    assign mem_read  = (r_state == StAccess) & ~r_we;
    assign mem_write = (r_state == StAccess) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign p0_ack    = (r_state == StResp) & ~r_owner;
    assign p1_ack    = (r_state == StResp) & r_owner;
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;
    assign busy      = (r_state != StIdle);
    assign owner     = r_owner;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single unified instruction/data memory port between two requesters.
- Port 0 is the multi-cycle processor's memory interface; port 1 is a secondary master (program loader / DMA).
- Latches the winning request, drives the memory for a parameterised number of wait cycles, then returns read data with a one-cycle ack.
- Sits between the processor top level and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles mem_read/mem_write are held before read data is sampled (legal range >=1).
- PRIO_RR, 1, 1 = round-robin on ties; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_rdata  out  DATA_W  port 0 read data, registered.
- p0_ack  out  1  port 0 completion pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ack: same as port 0, for port 1.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction in progress.
- owner  out  1  port index of current/last granted transaction.

Behaviour:
- FSM states IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values:
  - all outputs 0; p0_rdata = p1_rdata = 0; owner = 0.
  - internal last_grant = 1, so port 0 wins the first tie.
  - wait counter = 0.
- IDLE, no request: stay in IDLE.
- IDLE, any req high:
  - Pick winner. PRIO_RR=1 and both high: winner = !last_grant. PRIO_RR=0: port 0 wins whenever p0_req is high. Single request: that port wins.
  - At the clock edge, latch winner's addr/we/wdata into internal regs; owner <= winner; cnt <= MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_addr/mem_wdata driven from the latched regs.
  - mem_read = !we_latched; mem_write = we_latched. Both are combinational decodes of state, 0 outside ACCESS.
  - cnt decrements each cycle.
  - When cnt==0: on a read, capture mem_rdata into the owner's rdata reg; go to RESP.
- RESP:
  - Owner's ack = 1 for exactly this one cycle.
  - last_grant <= owner; go to IDLE.
- Latency: req sampled in IDLE at cycle 0 -> strobes high cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
  - Back-to-back transactions are spaced MEM_LAT+2 cycles apart.
- busy = (state != IDLE).
- Read data: pX_rdata changes only on completion of a read for port X and holds otherwise. Writes never alter rdata.
- Requester signals may change after grant; the latched copy is used, so mem_addr/mem_wdata are stable across ACCESS.
- Requester may keep req high after ack to issue a new request; it is evaluated fresh in the next IDLE cycle.
- req dropped mid-transaction is a protocol violation; the arbiter still completes the access and pulses ack.
- The non-owner's ack is never asserted. The two acks are never high in the same cycle.
- Reset mid-operation: immediate (asynchronous) return to IDLE.
  - mem_read/mem_write and acks drop without waiting for the clock edge.
  - The in-flight transaction is discarded; no ack is issued.
- MEM_LAT=1: ACCESS lasts one cycle, data sampled at the end of it.

Test Plan:
- Port 0 read, addr 0x10, MEM_LAT=2, memory returns 0xDEADBEEF -> mem_read=1 and mem_addr=0x10 in cycles 1-2; p0_ack=1 in cycle 3 only; p0_rdata=0xDEADBEEF; busy high cycles 1-3.
- Port 1 write, addr 0x20, wdata 0x12345678 -> mem_write=1 for 2 cycles with addr/wdata stable; mem_read=0; p1_ack once; p1_rdata unchanged (0).
- PRIO_RR=1, both reqs held high continuously -> grants p0,p1,p0,p1; acks alternate every 4 cycles; owner toggles accordingly.
- PRIO_RR=0, both held -> only p0_ack pulses; after p0_req drops, p1 is granted in the next IDLE and p1_ack follows 3 cycles later.
- rst pulsed in 2nd ACCESS cycle of a p0 read -> mem_read falls the same cycle; no p0_ack; p0_rdata=0; after release with p0_req still high, full 3-cycle transaction reruns.
- MEM_LAT=1, p0 read addr 0x4 then p0_addr changed to 0x8 in cycle 1 -> mem_addr stays 0x4; ack in cycle 2.
